// File: rtl/apb_slave_regfile21.sv
// apb_slave_regfile21: APB3 completer with a word-wide register bank, configurable
// wait states, decode-error response and a sticky protocol-violation flag.
module apb_slave_regfile21 #(
  parameter int PADDR_WIDTH21 = 32,
  parameter int PDATA_WIDTH21 = 32,
  parameter int NUM_REGS21    = 8,
  parameter int WAIT_STATES21 = 0,
  parameter int PSEL_INDEX21  = 0
) (
  input  logic                     pclock21,
  input  logic                     preset21,
  input  logic [PADDR_WIDTH21-1:0] paddr21,
  input  logic                     prwd21,
  input  logic [PDATA_WIDTH21-1:0] pwdata21,
  input  logic                     penable21,
  input  logic [15:0]              psel21,
  output logic [PDATA_WIDTH21-1:0] prdata21,
  output logic                     pready21,
  output logic                     pslverr21,
  output logic                     proto_err21
);

  localparam int IDX_W = $clog2(NUM_REGS21);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     sel;
  logic                     dec_err;
  logic                     setup;
  logic                     violation;
  logic                     abort;
  logic                     done;
  logic [IDX_W-1:0]         idx_q;
  logic                     wr_q;
  logic                     err_q;
  logic [PDATA_WIDTH21-1:0] wdata_q;
  logic [3:0]               cnt_q;
  logic                     proto_q;
  logic [PDATA_WIDTH21-1:0] regs [NUM_REGS21];

  assign sel = psel21[PSEL_INDEX21];

  // Any set bit above the register range is an error, so high addresses never alias.
  assign dec_err = (paddr21[1:0] != 2'b00) || ((paddr21 >> (IDX_W + 2)) != '0);

  assign setup     = (state == IDLE) && sel && !penable21;
  assign violation = (state == IDLE) && sel && penable21;
  assign abort     = (state == ACCESS) && !(sel && penable21);
  assign done      = (state == ACCESS) && sel && penable21 && (cnt_q == 4'd0);

  always_ff @(posedge pclock21 or negedge preset21) begin
    if (!preset21) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel && !penable21) state_next = ACCESS;
      ACCESS:  if (!(sel && penable21) || (cnt_q == 4'd0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pready21    = 1'b0;
    pslverr21   = 1'b0;
    prdata21    = '0;
    proto_err21 = proto_q;
    if ((state == ACCESS) && (cnt_q == 4'd0)) begin
      pready21  = 1'b1;
      pslverr21 = err_q;
      if (!wr_q && !err_q) prdata21 = regs[idx_q];
    end
  end

  // Setup-phase capture, wait countdown, sticky violation flag and write commit.
  always_ff @(posedge pclock21 or negedge preset21) begin
    if (!preset21) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      proto_q <= 1'b0;
      for (int i = 0; i < NUM_REGS21; i++) regs[i] <= '0;
    end else begin
      if (setup) begin
        idx_q   <= paddr21[IDX_W+1:2];
        wr_q    <= prwd21;
        err_q   <= dec_err;
        wdata_q <= pwdata21;
        cnt_q   <= 4'(WAIT_STATES21);
      end else if ((state == ACCESS) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (violation || abort) proto_q <= 1'b1;
      if (done && wr_q && !err_q) regs[idx_q] <= wdata_q;
    end
  end

endmodule

// File: doc/apb_slave_regfile21.md
# apb_slave_regfile21

APB3 responder (slave) with a bank of word-wide read/write registers. It answers transfers driven by the APB master on one bit of the 16-bit select bus and inserts a configurable number of wait states. It flags decode errors via `pslverr21` and reports master protocol violations via a sticky flag. It sits on the peripheral bus as the completer for master-side traffic and also serves as a known-good target for bus-level verification.

## Interface
- `PADDR_WIDTH21`, 32: address bus width.
- `PDATA_WIDTH21`, 32: read and write data width.
- `NUM_REGS21`, 8: number of registers. Power of two, 2..256.
- `WAIT_STATES21`, 0: `pready21`-low cycles in each access phase, 0..15.
- `PSEL_INDEX21`, 0: bit of `psel21` that selects this slave, 0..15.

Ports:
- `pclock21` in 1: the single clock. All logic uses its rising edge.
- `preset21` in 1: reset, asynchronous and active-low.
- `paddr21` in PADDR_WIDTH21: byte address.
- `prwd21` in 1: 1 = write, 0 = read.
- `pwdata21` in PDATA_WIDTH21: write data.
- `penable21` in 1: access-phase indicator.
- `psel21` in 16: one-hot slave selects. Only bit `PSEL_INDEX21` is used.
- `prdata21` out PDATA_WIDTH21: read data.
- `pready21` out 1: transfer complete.
- `pslverr21` out 1: transfer error.
- `proto_err21` out 1: sticky protocol-violation flag.

## Operation
- `sel` = `psel21[PSEL_INDEX21]`.
- Decode:
  - Register index is `paddr21 >> 2`.
  - Error condition `err` = (`paddr21[1:0]` != 0) OR (`paddr21` >= 4*`NUM_REGS21`).
- FSM states: IDLE, ACCESS.
- IDLE:
  - `sel`=1 and `penable21`=0 (setup phase): capture address, direction, `err` and write data; load wait counter with `WAIT_STATES21`; go to ACCESS.
  - `sel`=1 and `penable21`=1: protocol violation. Set `proto_err21`, stay in IDLE, produce no response.
- ACCESS:
  - `pready21` = (counter == 0).
  - Each edge with counter > 0: decrement the counter.
  - Edge with `pready21`=1: transfer completes and the FSM returns to IDLE.
    - Write without `err`: register[index] <= captured write data.
    - Write with `err`: no register changes.
  - Abort: `sel`=0 or `penable21`=0 at any edge in ACCESS before completion. Return to IDLE, set `proto_err21`, commit nothing.
  - Address, direction or write data changing during ACCESS is not checked. The values captured in setup are used.
- Back-to-back transfers always need a new setup phase. The completion edge and the next setup sample are distinct cycles.
- `proto_err21` stays high until reset.
- Width rules:
  - Register width is `PDATA_WIDTH21`.
  - Only `PADDR_WIDTH21` bits participate in decode; no aliasing above the register range.

## Timing
- Reset (`preset21` low, asynchronous): all registers 0, FSM IDLE, counter 0.
  - Outputs during reset: `prdata21`=0, `pready21`=0, `pslverr21`=0, `proto_err21`=0.
  - Reset during ACCESS abandons the transfer and commits no write.
- Outputs are decoded from registered state only; there is no combinational input-to-output path.
- Cycle numbering for a transfer:
  - Setup at cycle T0.
  - First access cycle T1.
  - `pready21` rises in cycle T1+`WAIT_STATES21` and completes at the end of that cycle.
  - Total transfer length: 2+`WAIT_STATES21` cycles.
- `pready21` is 0 in IDLE.
- `prdata21`: register[index] while in ACCESS with `pready21`=1 on a read without `err`; 0 otherwise, including on error and on writes.
- `pslverr21`: high only in the completion cycle (`pready21`=1) of an errored transfer; 0 otherwise.
- A read in the cycle right after a write completes returns the new value.

## Test plan
- Reset values: hold `preset21` low, drive random bus inputs -> all outputs 0. After release, a read of every register returns 0.
- Write/read, `WAIT_STATES21`=0: write 0xDEADBEEF to 0x08, then read 0x08.
  - `pready21` high in the first access cycle of each transfer.
  - Read returns 0xDEADBEEF with `pslverr21`=0.
  - Other registers still read 0.
- Wait states, `WAIT_STATES21`=3: read 0x04.
  - `pready21` low for 3 access cycles, high on the 4th.
  - `prdata21` is 0 until `pready21` is high.
- Decode errors: write 0xFFFFFFFF to 0x20 (`NUM_REGS21`=8) and to 0x02.
  - `pslverr21`=1 in the completion cycle of each.
  - Subsequent reads of 0x00 and 0x1C return their prior values.
- Protocol violations:
  - `penable21`=1 with `sel` in IDLE -> `proto_err21`=1 and no `pready21`.
  - Dropping `psel21` mid-access of a write to 0x0C -> register 3 is unchanged and `proto_err21` stays 1 until reset.
- Mid-transfer reset and select decoding:
  - Assert `preset21` low during the ACCESS of a write of 0x12345678 to 0x10 -> register 4 reads 0 afterward.
  - A transfer on a different `psel21` bit -> no response from this slave.
